shift_wb_stage: RTL and testbench

// - Writeback stage directly downstream of the combinational shift/rotate unit.
// - Captures each result beat (OUT, Co, destination register) in a small skid FIFO.
// - Writes the result into the register file and updates the C and Z flag registers.
// - Stalls upstream with a valid/ready handshake while the register-file write port is busy.

---
 rtl/shift_wb_stage.sv | 160 ++++++++++++++++
 tb/tb_shift_wb_stage.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_wb_stage.sv
// ----------------------------------------------------------------------------
// shift_wb_stage
//
// Writeback stage that sits directly after the combinational shift/rotate
// unit. Each result beat {res, co, rd} is captured in a small skid FIFO. The
// head of the FIFO is written into the register file, and the C and Z flags
// are updated when the head is popped.
//
// Handshake (upstream side): a beat transfers on a rising edge where
// in_valid=1 and in_ready=1. in_ready depends only on the occupancy register,
// so there is no combinational path from any input to in_ready. While
// in_valid=1 and in_ready=0 the producer must hold the beat stable.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a beat that arrives at an empty FIFO with no stall and no
//   flush is written straight through (0-cycle latency) and is not stored.
//   When undefined, every beat goes through the FIFO (1-cycle latency).
//
// Parameters
//   DATA_W  result width
//   ADDR_W  register-file address width
//   DEPTH   skid FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream beat handshake
//   in_res, in_co, in_rd       shifter OUT, Co and destination register
//   flush                      synchronous FIFO clear; blocks push and pop
//   wb_stall                   RF port taken by another writer; blocks pops
//   reg_we/reg_waddr/reg_wdata register-file write port (combinational)
//   flag_c, flag_z             carry and zero flag registers
//   occupancy                  FIFO entry count (the stage's state)
// ----------------------------------------------------------------------------
module shift_wb_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_res,
    input  logic                     in_co,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic                     flush,
    input  logic                     wb_stall,
    output logic                     reg_we,
    output logic [ADDR_W-1:0]        reg_waddr,
    output logic [DATA_W-1:0]        reg_wdata,
    output logic                     flag_c,
    output logic                     flag_z,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] res_mem [DEPTH];
    logic              co_mem  [DEPTH];
    logic [ADDR_W-1:0] rd_mem  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              head_valid;
    logic [DATA_W-1:0] head_res;
    logic              head_co;
    logic [ADDR_W-1:0] head_rd;
    logic              push;
    logic              pop;
    logic              bypass;

    assign head_valid = (occupancy != '0);
    assign in_ready   = (occupancy != FULL_CNT);

    assign head_res = res_mem[rd_ptr];
    assign head_co  = co_mem[rd_ptr];
    assign head_rd  = rd_mem[rd_ptr];

    // A flush cycle performs neither a push nor a pop.
    assign pop = head_valid & ~wb_stall & ~flush;

`ifdef WB_BYPASS_EN
    // rst_n is included so the write port reads as idle while reset is held,
    // even if upstream keeps presenting a beat.
    assign bypass = rst_n & ~head_valid & in_valid & ~wb_stall & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat is consumed by the write port and never stored.
    assign push = in_valid & in_ready & ~flush & ~bypass;

    // Write port. Address/data are gated to zero when nothing is presented so
    // the port reads as all-zero immediately on reset.
    always_comb begin
        reg_we    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        if (bypass) begin
            reg_we    = (in_rd != '0);
            reg_waddr = in_rd;
            reg_wdata = in_res;
        end else if (head_valid) begin
            // r0 is hard-wired zero: never write it, flags still update.
            reg_we    = pop & (head_rd != '0);
            reg_waddr = head_rd;
            reg_wdata = head_res;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + CNT_W'(1);
                    2'b01:   occupancy <= occupancy - CNT_W'(1);
                    default: occupancy <= occupancy;
                endcase
            end

            if (pop) begin
                flag_c <= head_co;
                flag_z <= (head_res == '0);
            end else if (bypass) begin
                flag_c <= in_co;
                flag_z <= (in_res == '0);
            end
        end
    end

    // Storage needs no reset: an entry is only read while occupancy covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr] <= in_res;
            co_mem[wr_ptr]  <= in_co;
            rd_mem[wr_ptr]  <= in_rd;
        end
    end

endmodule

// File: tb/tb_shift_wb_stage.sv
module tb_shift_wb_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_res;
    logic       in_co;
    logic [2:0] in_rd;
    logic       flush;
    logic       wb_stall;
    logic       reg_we;
    logic [2:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic       flag_c;
    logic       flag_z;
    logic [1:0] occupancy;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {rd, res} of every beat expected to reach the RF write port.
    logic [10:0] exp_q[$];

    // Bench model of the flag registers.
    logic mdl_c;
    logic mdl_z;

    shift_wb_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_co     (in_co),
        .in_rd     (in_rd),
        .flush     (flush),
        .wb_stall  (wb_stall),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .occupancy (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && reg_we === 1'b1) begin
            logic [10:0] exp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write",
                         reg_waddr, reg_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({reg_waddr, reg_wdata} !== exp) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             reg_waddr, reg_wdata, exp[10:8], exp[7:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    // waited = number of cycles the beat was held before acceptance.
    task automatic send(input logic [7:0] res, input logic co, input logic [2:0] rd,
                        output int waited);
        logic acc;
        waited   = 0;
        in_valid = 1'b1;
        in_res   = res;
        in_co    = co;
        in_rd    = rd;
        forever begin
            #1;
            acc = in_ready && !flush;
            if (acc && rd != 3'd0) exp_q.push_back({rd, res});
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat rd=%0d res=%02h not accepted, got in_ready=%0b required 1",
                         rd, res, in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        if (acc) begin
            mdl_c = co;
            mdl_z = (res == 8'h00);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1;
        checks++;
        if ({reg_we, reg_waddr, reg_wdata, flag_c, flag_z, occupancy, in_ready} !== {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got we=%0b waddr=%0d wdata=%02h c=%0b z=%0b occ=%0d rdy=%0b, required 0 0 00 0 0 0 1",
                     reg_we, reg_waddr, reg_wdata, flag_c, flag_z, occupancy, in_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_c = 1'b0;
        mdl_z = 1'b0;
    endtask

    task automatic test_single;
        int w;
        logic exp_we;
        send(8'h80, 1'b1, 3'd3, w);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        exp_we = 1'b0;
`else
        exp_we = 1'b1;
`endif
        checks++;
        if (reg_we !== exp_we) begin
            errors++;
            $display("FAIL single_latency: got reg_we=%0b required %0b", reg_we, exp_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({flag_c, flag_z, occupancy} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL single_flags: got c=%0b z=%0b occ=%0d required c=1 z=0 occ=0",
                     flag_c, flag_z, occupancy);
        end
    endtask

    task automatic test_zero;
        int w;
        send(8'h00, 1'b0, 3'd0, w);
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_r0_we: got reg_we=%0b required 0", reg_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({flag_c, flag_z} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_flags: got c=%0b z=%0b required c=0 z=1", flag_c, flag_z);
        end
    endtask

    task automatic test_stall_fill;
        int w;
        wb_stall = 1'b1;
        send(8'hA1, 1'b0, 3'd1, w);
        send(8'hB2, 1'b1, 3'd2, w);
        // Beat C presented while FULL: must be held.
        in_valid = 1'b1;
        in_res   = 8'hC3;
        in_co    = 1'b0;
        in_rd    = 3'd4;
        #1;
        checks++;
        if ({occupancy, in_ready} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL stall_full: got occ=%0d in_ready=%0b required occ=2 in_ready=0",
                     occupancy, in_ready);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if ({occupancy, in_ready} !== {2'd2, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got occ=%0d in_ready=%0b required occ=2 in_ready=0",
                         occupancy, in_ready);
            end
        end
        // Release: A, B, C on consecutive cycles; C accepted after A pops.
        wb_stall = 1'b0;
        exp_q.push_back({3'd4, 8'hC3});
        @(negedge clk);
        checks++;
        if ({reg_we, in_ready} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_release_a: got we=%0b in_ready=%0b required we=1 in_ready=0",
                     reg_we, in_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({reg_we, in_ready} !== {1'b1, 1'b1}) begin
            errors++;
            $display("FAIL stall_release_b: got we=%0b in_ready=%0b required we=1 in_ready=1",
                     reg_we, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_c: got we=%0b required 1", reg_we);
        end
        @(posedge clk);
        #1;
        mdl_c = 1'b0;
        mdl_z = 1'b0;
        checks++;
        if ({occupancy, flag_c, flag_z} !== {2'd0, mdl_c, mdl_z}) begin
            errors++;
            $display("FAIL stall_drain: got occ=%0d c=%0b z=%0b required occ=0 c=%0b z=%0b",
                     occupancy, flag_c, flag_z, mdl_c, mdl_z);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(1, 7)), w);
            checks++;
            if (w != 0 || occupancy > 2'd1) begin
                errors++;
                $display("FAIL stream_rate: beat %0d got wait=%0d occ=%0d required wait=0 occ<=1",
                         i, w, occupancy);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({flag_c, flag_z, occupancy} !== {mdl_c, mdl_z, 2'd0}) begin
            errors++;
            $display("FAIL stream_flags: got c=%0b z=%0b occ=%0d required c=%0b z=%0b occ=0",
                     flag_c, flag_z, occupancy, mdl_c, mdl_z);
        end
    endtask

    task automatic test_flush;
        int w;
        wb_stall = 1'b1;
        send(8'h11, 1'b1, 3'd5, w);
        send(8'h00, 1'b1, 3'd6, w);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        // The beats never write; the flag model keeps its pre-flush value.
        mdl_c = flag_c;
        mdl_z = flag_z;
        flush    = 1'b1;
        wb_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_pop: got reg_we=%0b required 0", reg_we);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if ({occupancy, in_ready} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL flush_empty: got occ=%0d in_ready=%0b required occ=0 in_ready=1",
                     occupancy, in_ready);
        end
        // A push in a flush cycle is dropped, and nothing is bypassed.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_res   = 8'h5A;
        in_co    = 1'b0;
        in_rd    = 3'd4;
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_push_we: got reg_we=%0b required 0", reg_we);
        end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({occupancy, flag_c, flag_z} !== {2'd0, mdl_c, mdl_z}) begin
            errors++;
            $display("FAIL flush_push_dropped: got occ=%0d c=%0b z=%0b required occ=0 c=%0b z=%0b",
                     occupancy, flag_c, flag_z, mdl_c, mdl_z);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        send(8'h80, 1'b1, 3'd2, w);
        @(posedge clk);
        #1;
        checks++;
        if ({flag_c, flag_z} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset_flags: got c=%0b z=%0b required c=1 z=0", flag_c, flag_z);
        end
        wb_stall = 1'b1;
        send(8'h33, 1'b0, 3'd6, w);
        void'(exp_q.pop_back());
        #1;
        checks++;
        if ({reg_we, reg_waddr, reg_wdata, occupancy} !== {1'b0, 3'd6, 8'h33, 2'd1}) begin
            errors++;
            $display("FAIL stalled_head: got we=%0b waddr=%0d wdata=%02h occ=%0d required 0 6 33 1",
                     reg_we, reg_waddr, reg_wdata, occupancy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({reg_we, reg_waddr, reg_wdata, flag_c, flag_z, occupancy, in_ready} !== {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got we=%0b waddr=%0d wdata=%02h c=%0b z=%0b occ=%0d rdy=%0b, required 0 0 00 0 0 0 1",
                     reg_we, reg_waddr, reg_wdata, flag_c, flag_z, occupancy, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wb_stall = 1'b0;
        mdl_c    = 1'b0;
        mdl_z    = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({occupancy, reg_we} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dropped: got occ=%0d we=%0b required occ=0 we=0", occupancy, reg_we);
        end
    endtask

    task automatic test_bypass_latency;
        logic exp_we0;
        logic [1:0] exp_occ1;
`ifdef WB_BYPASS_EN
        exp_we0  = 1'b1;
        exp_occ1 = 2'd0;
`else
        exp_we0  = 1'b0;
        exp_occ1 = 2'd1;
`endif
        in_valid = 1'b1;
        in_res   = 8'h01;
        in_co    = 1'b1;
        in_rd    = 3'd5;
        exp_q.push_back({3'd5, 8'h01});
        @(negedge clk);
        checks++;
        if ({reg_we, occupancy} !== {exp_we0, 2'd0}) begin
            errors++;
            $display("FAIL latency_accept_cycle: got we=%0b occ=%0d required we=%0b occ=0",
                     reg_we, occupancy, exp_we0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({reg_we, occupancy} !== {~exp_we0, exp_occ1}) begin
            errors++;
            $display("FAIL latency_next_cycle: got we=%0b occ=%0d required we=%0b occ=%0d",
                     reg_we, occupancy, ~exp_we0, exp_occ1);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({flag_c, flag_z, occupancy} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL latency_flags: got c=%0b z=%0b occ=%0d required c=1 z=0 occ=0",
                     flag_c, flag_z, occupancy);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_res   = 8'h00;
        in_co    = 1'b0;
        in_rd    = 3'd0;
        flush    = 1'b0;
        wb_stall = 1'b0;
        mdl_c    = 1'b0;
        mdl_z    = 1'b0;

        test_reset();
        test_single();
        test_zero();
        test_stall_fill();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_bypass_latency();

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
